// File: rtl/sys_op_sequencer_pkg.sv
// Shared types for the SYSTEM-instruction sequencer.
//
// Contents:
//   decode_sys_op_t   - decoded SYSTEM-class operation presented by issue
//   sys_seq_state_t   - sequencer FSM state encoding
//   sys_op_fields_t   - fixed-width fields latched when an op is accepted
//   is_csr_op()       - true for the three CSR read-modify-write ops
//   PC_STEP           - instruction size used for the post-CSR redirect
package sys_op_sequencer_pkg;

    typedef enum logic [2:0] {
        SYS_NONE   = 3'd0,
        SYS_CSRRW  = 3'd1,   // swap
        SYS_CSRRS  = 3'd2,   // set bits
        SYS_CSRRC  = 3'd3,   // clear bits
        SYS_ECALL  = 3'd4,
        SYS_EBREAK = 3'd5,
        SYS_MRET   = 3'd6,
        SYS_SRET   = 3'd7
    } decode_sys_op_t;

    typedef enum logic [2:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_DRAIN = 3'd1,
        SEQ_CHECK = 3'd2,
        SEQ_READ  = 3'd3,
        SEQ_WRITE = 3'd4,
        SEQ_FLUSH = 3'd5,
        SEQ_TRAP  = 3'd6
    } sys_seq_state_t;

    typedef struct packed {
        decode_sys_op_t op;
        logic [11:0]    csr;
        logic           rs1_is_zero;
        logic [4:0]     rd;
    } sys_op_fields_t;

    localparam int unsigned PC_STEP = 4;

    function automatic logic is_csr_op(input decode_sys_op_t op);
        return (op == SYS_CSRRW) || (op == SYS_CSRRS) || (op == SYS_CSRRC);
    endfunction

endpackage

// File: rtl/sys_op_sequencer_csr_wdata_alu.sv
// CSR write-data ALU: computes the new CSR value and whether a write happens.
// Kept separate so CSR forwarding logic can reuse the same rules.
//
// Ports:
//   op_i           - decoded sys op
//   rs1_is_zero_i  - rs1 index is x0 (set/clear with x0 must not write)
//   old_i          - current CSR value
//   rs1_i          - rs1 operand
//   new_o          - value to write into the CSR
//   wr_e_o         - a CSR write is architecturally required
module csr_wdata_alu
    import sys_op_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  decode_sys_op_t  op_i,
    input  logic            rs1_is_zero_i,
    input  logic [XLEN-1:0] old_i,
    input  logic [XLEN-1:0] rs1_i,
    output logic [XLEN-1:0] new_o,
    output logic            wr_e_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        new_o  = old_i;
        wr_e_o = 1'b0;
        case (op_i)
            SYS_CSRRW: begin
                new_o  = rs1_i;
                wr_e_o = 1'b1;
            end
            SYS_CSRRS: begin
                new_o  = old_i | rs1_i;
                wr_e_o = !rs1_is_zero_i;
            end
            SYS_CSRRC: begin
                new_o  = old_i & ~rs1_i;
                wr_e_o = !rs1_is_zero_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sys_op_sequencer.sv
// Serialising controller for SYSTEM-class instructions. Accepts one op from
// issue, waits for the pipeline to drain, asks sys_unit for a legality check,
// then either performs a CSR read-modify-write (writeback + flush to pc+4) or
// raises a trap to commit. Only one op is in flight at a time.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_valid / o_ready        issue handshake (ready only in IDLE)
//   i_op .. i_pc             op fields, latched on accept
//   i_pipe_empty             older instructions fully retired
//   i_kill                   older-instr flush; aborts op before the check
//   o_sys_e, o_sys_*         enable + latched op to sys_unit
//   i_bad_csr, i_trap        sys_unit verdict, sampled in CHECK
//   o_csr_rd_e, o_csr_num    CSR read strobe / address (data next cycle)
//   i_csr_rd_data            CSR read data
//   o_csr_wr_e/_wr_data      CSR write strobe / data
//   o_wb_*                   GPR writeback of the old CSR value
//   o_flush, o_flush_pc      pipeline redirect after a CSR op
//   o_except*                trap request to commit
//   o_stall_cnt              saturating count of stalled DRAIN cycles
module sys_op_sequencer
    import sys_op_sequencer_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  decode_sys_op_t         i_op,
    input  logic [11:0]            i_csr,
    input  logic                   i_rs1_is_zero,
    input  logic [XLEN-1:0]        i_rs1_val,
    input  logic [4:0]             i_rd,
    input  logic [XLEN-1:0]        i_pc,
    input  logic                   i_pipe_empty,
    input  logic                   i_kill,
    output logic                   o_sys_e,
    output decode_sys_op_t         o_sys_op,
    output logic [11:0]            o_sys_csr,
    output logic                   o_sys_rs1_is_zero,
    input  logic                   i_bad_csr,
    input  logic                   i_trap,
    output logic                   o_csr_rd_e,
    output logic [11:0]            o_csr_num,
    input  logic [XLEN-1:0]        i_csr_rd_data,
    output logic                   o_csr_wr_e,
    output logic [XLEN-1:0]        o_csr_wr_data,
    output logic                   o_wb_valid,
    output logic [4:0]             o_wb_rd,
    output logic [XLEN-1:0]        o_wb_data,
    output logic                   o_flush,
    output logic [XLEN-1:0]        o_flush_pc,
    output logic                   o_except,
    output logic                   o_except_illegal,
    output decode_sys_op_t         o_except_op,
    output logic [XLEN-1:0]        o_except_pc,
    output logic [STALL_CNT_W-1:0] o_stall_cnt
);

    sys_seq_state_t         state_q,     state_d;
    sys_op_fields_t         fields_q,    fields_d;
    logic [XLEN-1:0]        rs1_q,       rs1_d;
    logic [XLEN-1:0]        pc_q,        pc_d;
    logic                   illegal_q,   illegal_d;
    logic [XLEN-1:0]        flush_pc_q,  flush_pc_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   sys_e_q,     sys_e_d;
    logic                   csr_rd_e_q,  csr_rd_e_d;
    logic                   flush_q,     flush_d;
    logic                   except_q,    except_d;

    logic [XLEN-1:0]        alu_new;
    logic                   alu_wr_e;
    logic                   in_write;

    csr_wdata_alu #(
        .XLEN (XLEN)
    ) u_csr_wdata_alu (
        .op_i          (fields_q.op),
        .rs1_is_zero_i (fields_q.rs1_is_zero),
        .old_i         (i_csr_rd_data),
        .rs1_i         (rs1_q),
        .new_o         (alu_new),
        .wr_e_o        (alu_wr_e)
    );

    // Next-state and next-output logic. Strobes are computed one cycle early
    // (on the transition into their state) so they come straight from flops.
    always_comb begin
        state_d     = state_q;
        fields_d    = fields_q;
        rs1_d       = rs1_q;
        pc_d        = pc_q;
        illegal_d   = illegal_q;
        flush_pc_d  = flush_pc_q;
        stall_cnt_d = stall_cnt_q;
        sys_e_d     = 1'b0;
        csr_rd_e_d  = 1'b0;
        flush_d     = 1'b0;
        except_d    = 1'b0;

        // Stall cycles are counted even if the op is later killed: the
        // pipeline really was held for them.
        if (state_q == SEQ_DRAIN && !i_pipe_empty && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end

        case (state_q)
            SEQ_IDLE: begin
                if (i_valid && !i_kill) begin
                    fields_d.op          = i_op;
                    fields_d.csr         = i_csr;
                    fields_d.rs1_is_zero = i_rs1_is_zero;
                    fields_d.rd          = i_rd;
                    rs1_d                = i_rs1_val;
                    pc_d                 = i_pc;
                    state_d              = SEQ_DRAIN;
                end
            end
            SEQ_DRAIN: begin
                if (i_kill) begin
                    state_d = SEQ_IDLE;
                end else if (i_pipe_empty) begin
                    state_d = SEQ_CHECK;
                    sys_e_d = 1'b1;
                end
            end
            SEQ_CHECK: begin
                if (i_kill) begin
                    state_d = SEQ_IDLE;
                end else if (i_trap || i_bad_csr) begin
                    state_d   = SEQ_TRAP;
                    except_d  = 1'b1;
                    // A trap op wins over a simultaneous bad-CSR verdict.
                    illegal_d = i_bad_csr && !i_trap;
                end else begin
                    state_d    = SEQ_READ;
                    csr_rd_e_d = 1'b1;
                end
            end
            SEQ_READ: begin
                state_d = SEQ_WRITE;
            end
            SEQ_WRITE: begin
                state_d    = SEQ_FLUSH;
                flush_d    = 1'b1;
                flush_pc_d = pc_q + XLEN'(PC_STEP);
            end
            SEQ_FLUSH: state_d = SEQ_IDLE;
            SEQ_TRAP:  state_d = SEQ_IDLE;
            default:   state_d = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (i_rst) begin
            state_q     <= SEQ_IDLE;
            fields_q    <= '0;
            rs1_q       <= '0;
            pc_q        <= '0;
            illegal_q   <= 1'b0;
            flush_pc_q  <= '0;
            stall_cnt_q <= '0;
            sys_e_q     <= 1'b0;
            csr_rd_e_q  <= 1'b0;
            flush_q     <= 1'b0;
            except_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            fields_q    <= fields_d;
            rs1_q       <= rs1_d;
            pc_q        <= pc_d;
            illegal_q   <= illegal_d;
            flush_pc_q  <= flush_pc_d;
            stall_cnt_q <= stall_cnt_d;
            sys_e_q     <= sys_e_d;
            csr_rd_e_q  <= csr_rd_e_d;
            flush_q     <= flush_d;
            except_q    <= except_d;
        end
    end

    assign in_write = (state_q == SEQ_WRITE);

    assign o_ready           = (state_q == SEQ_IDLE);
    // A kill arriving in the CHECK cycle must suppress the enable in that
    // same cycle, so the registered enable is masked combinationally.
    assign o_sys_e           = sys_e_q && !i_kill;
    assign o_sys_op          = fields_q.op;
    assign o_sys_csr         = fields_q.csr;
    assign o_sys_rs1_is_zero = fields_q.rs1_is_zero;

    assign o_csr_rd_e        = csr_rd_e_q;
    assign o_csr_num         = fields_q.csr;

    // Read data only arrives during WRITE, so the write and the writeback are
    // driven straight from it; a reset in that cycle cancels both.
    assign o_csr_wr_e        = in_write && alu_wr_e && !i_rst;
    assign o_csr_wr_data     = in_write ? alu_new : '0;
    assign o_wb_valid        = in_write && is_csr_op(fields_q.op) &&
                               (fields_q.rd != 5'd0) && !i_rst;
    assign o_wb_rd           = fields_q.rd;
    assign o_wb_data         = in_write ? i_csr_rd_data : '0;

    assign o_flush           = flush_q;
    assign o_flush_pc        = flush_pc_q;

    assign o_except          = except_q;
    assign o_except_illegal  = illegal_q;
    assign o_except_op       = fields_q.op;
    assign o_except_pc       = pc_q;

    assign o_stall_cnt       = stall_cnt_q;

endmodule
